// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the instruction fetch unit, instruction memory and decode.
// The master modport is the fetch unit. The slave modport is its environment.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        PCSrc;
   logic [31:0] BranchTarget;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_valid, Instr, InstrPC,
      input  instr_ready, PCSrc, BranchTarget
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_valid, Instr, InstrPC,
      output instr_ready, PCSrc, BranchTarget
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: in-order word requests, credit-limited prefetch FIFO,
// and a redirect flush that discards responses still in flight.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

   logic [31:0]   fetch_pc_reg;
   logic [31:0]   rsp_pc_reg;
   logic [CW-1:0] inflight_reg;
   logic [CW-1:0] drop_reg;
   logic [CW-1:0] wr_ptr_reg;
   logic [CW-1:0] rd_ptr_reg;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic [CW-1:0] occupancy;
   logic [CW:0]   credit_used;
   logic [31:0]   target;
   logic          empty, full, accept, rsp, push, pop, redirect;
   logic [CW-1:0] inflight_next, drop_next;

   assign occupancy   = wr_ptr_reg - rd_ptr_reg;
   assign credit_used = {1'b0, occupancy} + {1'b0, inflight_reg};
   assign empty       = (occupancy == '0);
   assign full        = (occupancy == FULL_C);
   assign target      = bus.BranchTarget & 32'hFFFF_FFFC;
   assign redirect    = bus.PCSrc;
   assign rsp         = bus.imem_rsp_valid;

   // Every slot either buffered or still owed by memory consumes a credit, so the FIFO cannot overflow.
   assign bus.imem_req_valid = reset && !redirect && (credit_used < DEPTH_C);
   assign bus.imem_req_addr  = fetch_pc_reg;
   assign bus.instr_valid    = !empty && !redirect;
   assign bus.Instr          = empty ? 32'h0 : data_mem[rd_ptr_reg[AW-1:0]];
   assign bus.InstrPC        = empty ? 32'h0 : pc_mem[rd_ptr_reg[AW-1:0]];

   assign accept = bus.imem_req_valid && bus.imem_req_ready;
   assign push   = rsp && (drop_reg == '0) && !redirect;
   assign pop    = bus.instr_valid && bus.instr_ready;

   assign inflight_next = inflight_reg + CW'(accept) - CW'(rsp);

   // A redirect marks every outstanding request as wrong-path; inflight itself is never cleared.
   always_comb begin
      drop_next = drop_reg;
      if (redirect)
         drop_next = inflight_reg - CW'(rsp);
      else if (rsp && (drop_reg != '0))
         drop_next = drop_reg - CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_reg <= RESET_PC;
         rsp_pc_reg   <= RESET_PC;
         inflight_reg <= '0;
         drop_reg     <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         inflight_reg <= inflight_next;
         drop_reg     <= drop_next;
         if (redirect) begin
            fetch_pc_reg <= target;
            rsp_pc_reg   <= target;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
         end else begin
            if (accept)
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
            if (push) begin
               rsp_pc_reg <= rsp_pc_reg + 32'd4;
               wr_ptr_reg <= wr_ptr_reg + CW'(1);
            end
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_reg[AW-1:0]] <= bus.imem_rsp_data;
         pc_mem[wr_ptr_reg[AW-1:0]]   <= rsp_pc_reg;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));
   a_no_inflight_underflow: assert property (@(posedge clk) disable iff (!reset) !(rsp && (inflight_reg == '0)));
   a_no_inflight_overflow: assert property (@(posedge clk) disable iff (!reset) !(accept && ({1'b0, inflight_reg} >= DEPTH_C)));
endmodule
